// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the N:1 handshaked multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the mode input.
//   clog2()              : ceiling log2, used to size the channel-select fields.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(6) = 3, clog2(8) = 3.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: combinational round-robin channel picker.
//   req         in  CHANNELS  per-channel request (valid) vector
//   ptr         in  SEL_W     channel granted most recently
//   burst_ok    in  1         ptr may be granted again without rotating
//   grant       out SEL_W     chosen channel index
//   grant_valid out 1         a channel was chosen
// Rotation searches ptr+1, ptr+2, ... wrapping, and ends at ptr itself, so a lone
// requester at ptr is always re-granted.
module mux_rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    localparam int unsigned SEL_W = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                burst_ok,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    logic [2*CHANNELS-1:0] req_dbl;
    logic [CHANNELS-1:0]   req_rot;
    logic [SEL_W:0]        base;
    logic [SEL_W-1:0]      rot_grant;
    logic                  rot_hit;

    always_comb begin
        // Doubling the vector turns the wrap-around search into a plain slice:
        // bit i of req_rot is channel (ptr + 1 + i) mod CHANNELS.
        req_dbl   = {req, req};
        base      = {1'b0, ptr} + (SEL_W + 1)'(1);
        req_rot   = req_dbl[base +: CHANNELS];
        rot_hit   = 1'b0;
        rot_grant = '0;
        // Descending scan so the lowest set bit (nearest to ptr+1) wins.
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            int t;
            t = int'(ptr) + 1 + i;
            if (t >= int'(CHANNELS)) begin
                t = t - int'(CHANNELS);
            end
            if (req_rot[i]) begin
                rot_hit   = 1'b1;
                rot_grant = SEL_W'(t);
            end
        end

        if (burst_ok && req[ptr]) begin
            grant       = ptr;
            grant_valid = 1'b1;
        end else begin
            grant       = rot_grant;
            grant_valid = rot_hit;
        end
    end

endmodule

// File: rtl/mux_nx1_hs.sv
// mux_nx1_hs: N-channel, W-bit registered multiplexer with valid/ready on every
// input and on the output. Fixed-select or round-robin (burst-limited) arbitration.
//   clk         in  1               rising-edge clock
//   rst_n       in  1               asynchronous active-low reset
//   mode        in  1               MODE_FIXED (use sel) or MODE_RR (round-robin)
//   sel         in  SEL_W           channel index in fixed mode
//   din         in  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
//   din_valid   in  CHANNELS        per-channel valid
//   din_ready   out CHANNELS        per-channel ready, one-hot or zero
//   dout        out WIDTH           registered output word
//   dout_ch     out SEL_W           channel dout came from
//   dout_valid  out 1               output valid
//   dout_ready  in  1               consumer ready
module mux_nx1_hs
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned BURST    = 1,
    localparam int unsigned SEL_W   = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       din_valid,
    output logic [CHANNELS-1:0]       din_ready,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
    input  logic                      dout_ready
);

    localparam int unsigned       CNT_W   = clog2(BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_C = CNT_W'(BURST);
    localparam logic [SEL_W:0]    CH_EXT  = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  PTR_RST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             load;
    logic             burst_ok;
    logic             xfer;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_grant_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;

    assign load = !valid_q || dout_ready;

    // cnt_q == 0 only after reset: no burst is in progress, so ptr (CHANNELS-1)
    // must not be favoured and the search starts at channel 0.
    assign burst_ok = (cnt_q != '0) && (cnt_q < BURST_C);

    mux_rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .req         (din_valid),
        .ptr         (ptr_q),
        .burst_ok    (burst_ok),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_grant_valid;
        end else begin
            grant       = sel;
            // Out-of-range sel (non-power-of-2 CHANNELS) never grants.
            grant_valid = ({1'b0, sel} < CH_EXT) && din_valid[sel];
        end
    end

    assign xfer = load && grant_valid;

    always_comb begin
        din_ready = '0;
        if (xfer) begin
            din_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        dout_d  = dout_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            dout_d  = din[grant*WIDTH +: WIDTH];
            ch_d    = grant;
            valid_d = 1'b1;
            if (grant != ptr_q) begin
                ptr_d = grant;
                cnt_d = CNT_W'(1);
            end else if (mode == MODE_RR && !burst_ok) begin
                // Re-granted by the wrap search after the burst ran out: new burst.
                cnt_d = CNT_W'(1);
            end else if (cnt_q < BURST_C) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
        end else begin
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = ch_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_mux_nx1_hs.sv
// Bench for mux_nx1_hs: three instances (8ch/BURST1, 8ch/BURST3, 6ch/BURST2) driven
// by directed and random stimulus, checked every cycle against a behavioural model.
module tb_mux_nx1_hs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] din_all;

    logic       mode_a [3];
    logic [2:0] sel_a  [3];
    logic [7:0] dv_a   [3];
    logic       dr_a   [3];
    logic [7:0] rdy_a  [3];
    logic [7:0] dout_a [3];
    logic [2:0] ch_a   [3];
    logic       ov_a   [3];

    int n_checks = 0;
    int n_errors = 0;

    // Model state (m_*) and next state (n_*), per instance.
    int         m_ptr [3], m_cnt [3], m_ch [3];
    logic       m_valid [3];
    logic [7:0] m_dout [3];
    int         n_ptr [3], n_cnt [3], n_ch [3];
    logic       n_valid [3];
    logic [7:0] n_dout [3];

    int seq3 [9] = '{2, 2, 2, 5, 5, 5, 2, 2, 2};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned C = (k == 2) ? 6 : 8;
        localparam int unsigned B = (k == 0) ? 1 : ((k == 1) ? 3 : 2);
        logic [C*8-1:0] din_k;
        logic [C-1:0]   dv_k;
        logic [C-1:0]   rdy_k;
        assign din_k    = din_all[C*8-1:0];
        assign dv_k     = dv_a[k][C-1:0];
        assign rdy_a[k] = 8'(rdy_k);

        mux_nx1_hs #(
            .WIDTH    (8),
            .CHANNELS (C),
            .BURST    (B)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .mode       (mode_a[k]),
            .sel        (sel_a[k]),
            .din        (din_k),
            .din_valid  (dv_k),
            .din_ready  (rdy_k),
            .dout       (dout_a[k]),
            .dout_ch    (ch_a[k]),
            .dout_valid (ov_a[k]),
            .dout_ready (dr_a[k])
        );
    end

    function automatic int cof(input int k);
        return (k == 2) ? 6 : 8;
    endfunction

    function automatic int bof(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ptr[k]   = cof(k) - 1;
            m_cnt[k]   = 0;
            m_ch[k]    = 0;
            m_valid[k] = 1'b0;
            m_dout[k]  = 8'h00;
        end
    endtask

    // Check outputs against the model and compute the model's next state.
    task automatic model_eval();
        for (int k = 0; k < 3; k++) begin
            int         c, b, g, idx;
            logic       gv, ld;
            logic [7:0] exp_rdy;
            c  = cof(k);
            b  = bof(k);
            ld = !m_valid[k] || dr_a[k];
            gv = 1'b0;
            g  = 0;
            if (mode_a[k] == 1'b0) begin
                g  = int'(sel_a[k]);
                gv = (g < c) && dv_a[k][g];
            end else if (m_cnt[k] > 0 && m_cnt[k] < b && dv_a[k][m_ptr[k]]) begin
                g  = m_ptr[k];
                gv = 1'b1;
            end else begin
                for (int j = 1; j <= c; j++) begin
                    idx = (m_ptr[k] + j) % c;
                    if (!gv && dv_a[k][idx]) begin
                        g  = idx;
                        gv = 1'b1;
                    end
                end
            end
            exp_rdy = (ld && gv) ? 8'(1 << g) : 8'h00;
            chk($sformatf("din_ready[%0d]", k), 64'(rdy_a[k]), 64'(exp_rdy));
            chk($sformatf("dout_valid[%0d]", k), 64'(ov_a[k]), 64'(m_valid[k]));
            chk($sformatf("dout[%0d]", k), 64'(dout_a[k]), 64'(m_dout[k]));
            chk($sformatf("dout_ch[%0d]", k), 64'(ch_a[k]), 64'(m_ch[k]));

            n_ptr[k]   = m_ptr[k];
            n_cnt[k]   = m_cnt[k];
            n_ch[k]    = m_ch[k];
            n_valid[k] = m_valid[k];
            n_dout[k]  = m_dout[k];
            if (ld && gv) begin
                n_valid[k] = 1'b1;
                n_dout[k]  = din_all[g*8 +: 8];
                n_ch[k]    = g;
                if (g != m_ptr[k]) begin
                    n_ptr[k] = g;
                    n_cnt[k] = 1;
                end else if (mode_a[k] && !(m_cnt[k] > 0 && m_cnt[k] < b)) begin
                    n_cnt[k] = 1;
                end else begin
                    n_cnt[k] = (m_cnt[k] + 1 > b) ? b : m_cnt[k] + 1;
                end
            end else if (ld) begin
                n_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic model_commit();
        for (int k = 0; k < 3; k++) begin
            m_ptr[k]   = n_ptr[k];
            m_cnt[k]   = n_cnt[k];
            m_ch[k]    = n_ch[k];
            m_valid[k] = n_valid[k];
            m_dout[k]  = n_dout[k];
        end
    endtask

    // One clock: check at negedge, advance the model at posedge, return at posedge+1.
    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_all(input logic md, input logic [2:0] s, input logic [7:0] dv,
                           input logic dr);
        for (int k = 0; k < 3; k++) begin
            mode_a[k] = md;
            sel_a[k]  = s;
            dv_a[k]   = dv;
            dr_a[k]   = dr;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 64'(ov_a[k]), 64'h0);
            chk($sformatf("rst_dout[%0d]", k), 64'(dout_a[k]), 64'h0);
            chk($sformatf("rst_ch[%0d]", k), 64'(ch_a[k]), 64'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int         hch, nxt;
        logic [7:0] held, exp_data;

        set_all(1'b0, 3'd0, 8'h00, 1'b0);
        din_all = 64'h0;
        do_reset();

        // Fixed select of channel 3.
        set_all(1'b0, 3'd3, 8'h08, 1'b1);
        din_all = {$urandom, $urandom};
        din_all[31:24] = 8'hA5;
        #1;
        chk("t1_ready", 64'(rdy_a[0]), 64'h08);
        tick();
        chk("t1_dout", 64'(dout_a[0]), 64'hA5);
        chk("t1_ch", 64'(ch_a[0]), 64'd3);
        chk("t1_valid", 64'(ov_a[0]), 64'd1);

        // Pure round-robin over all eight channels.
        do_reset();
        set_all(1'b1, 3'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 9; i++) begin
            din_all = {$urandom, $urandom};
            tick();
            chk($sformatf("t2_ch%0d", i), 64'(ch_a[0]), 64'(i % 8));
            chk($sformatf("t2_valid%0d", i), 64'(ov_a[0]), 64'd1);
        end

        // BURST = 3 with channels 2 and 5.
        do_reset();
        set_all(1'b1, 3'd0, 8'h24, 1'b1);
        for (int i = 0; i < 9; i++) begin
            din_all = {$urandom, $urandom};
            tick();
            chk($sformatf("t3_ch%0d", i), 64'(ch_a[1]), 64'(seq3[i]));
        end

        // Stall for four cycles, then release.
        set_all(1'b1, 3'd0, 8'hFF, 1'b1);
        tick();
        held = dout_a[0];
        hch  = int'(ch_a[0]);
        for (int k = 0; k < 3; k++) dr_a[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din_all = {$urandom, $urandom};
            #1;
            chk("t4_ready_stall", 64'(rdy_a[0]), 64'h0);
            tick();
            chk("t4_dout_hold", 64'(dout_a[0]), 64'(held));
            chk("t4_ch_hold", 64'(ch_a[0]), 64'(hch));
        end
        for (int k = 0; k < 3; k++) dr_a[k] = 1'b1;
        nxt      = (hch + 1) % 8;
        exp_data = din_all[nxt*8 +: 8];
        #1;
        chk("t4_ready_release", 64'(rdy_a[0]), 64'(8'(1 << nxt)));
        tick();
        chk("t4_dout_new", 64'(dout_a[0]), 64'(exp_data));
        chk("t4_ch_new", 64'(ch_a[0]), 64'(nxt));

        // Six channels: sel = 7 never grants; pending word drains.
        set_all(1'b0, 3'd1, 8'h3F, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) dr_a[k] = 1'b0;
        tick();
        chk("t5_held_valid", 64'(ov_a[2]), 64'd1);
        set_all(1'b0, 3'd7, 8'h3F, 1'b1);
        #1;
        chk("t5_ready", 64'(rdy_a[2]), 64'h0);
        tick();
        chk("t5_valid_drop", 64'(ov_a[2]), 64'd0);
        chk("t5_ready2", 64'(rdy_a[2]), 64'h0);
        tick();
        chk("t5_valid_stays", 64'(ov_a[2]), 64'd0);

        // Reset in the middle of a stall.
        set_all(1'b1, 3'd0, 8'hFF, 1'b1);
        tick();
        tick();
        for (int k = 0; k < 3; k++) dr_a[k] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_rst_valid[%0d]", k), 64'(ov_a[k]), 64'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_all(1'b1, 3'd0, 8'hFF, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_first_ch[%0d]", k), 64'(ch_a[k]), 64'd0);
            chk($sformatf("t6_first_valid[%0d]", k), 64'(ov_a[k]), 64'd1);
        end

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 7) == 0) mode_a[k] = ($urandom_range(0, 3) != 0);
                sel_a[k] = 3'($urandom_range(0, 7));
                dv_a[k]  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
                dr_a[k]  = ($urandom_range(0, 3) != 0);
            end
            din_all = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
